// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared single-digit BCD cell is
// stepped LSD-first, one digit per clock, with the carry held in a register.

module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] t;
    logic [4:0] u;

    always_comb begin
        t  = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        u  = t + 5'd6;
        co = (t > 5'd9);
        s  = co ? u[3:0] : t[3:0];
    end
endmodule

module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] op_a,
    input  logic [4*DIGITS-1:0] op_b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    state_t              next_state;
    logic [IW-1:0]       idx;
    logic                carry_reg;
    logic [4*DIGITS-1:0] a_reg;
    logic [4*DIGITS-1:0] b_reg;
    logic [3:0]          cell_s;
    logic                cell_co;
    logic                bad_digit;

    bcd_digit_add u_cell (
        .a  (a_reg[4*idx +: 4]),
        .b  (b_reg[4*idx +: 4]),
        .ci (carry_reg),
        .s  (cell_s),
        .co (cell_co)
    );

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (op_a[4*i +: 4] > 4'd9 || op_b[4*i +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (idx == LAST) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == RUN);
            done  <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    a_reg     <= op_a;
                    b_reg     <= op_b;
                    carry_reg <= cin;
                    idx       <= '0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    invalid   <= bad_digit;
                end
                RUN: begin
                    sum[4*idx +: 4] <= cell_s;
                    carry_reg       <= cell_co;
                    // Last digit: expose the carry and park idx at zero.
                    if (idx == LAST) begin
                        cout <= cell_co;
                        idx  <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
